// File: rtl/rggen_apb_host_adapter.sv
// APB4 slave front end for a generated register block: one APB transfer becomes
// one request broadcast to all register slices, and the captured answer goes back to APB.
module rggen_apb_host_adapter #(
  parameter int ADDRESS_WIDTH  = 16,
  parameter int DATA_WIDTH     = 32,
  parameter int REGISTERS      = 1,
  parameter int TIMEOUT_CYCLES = 0
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            i_psel,
  input  logic                            i_penable,
  input  logic [ADDRESS_WIDTH-1:0]        i_paddr,
  input  logic                            i_pwrite,
  input  logic [DATA_WIDTH-1:0]           i_pwdata,
  input  logic [DATA_WIDTH/8-1:0]         i_pstrb,
  output logic                            o_pready,
  output logic [DATA_WIDTH-1:0]           o_prdata,
  output logic                            o_pslverr,
  output logic                            o_register_request,
  output logic [ADDRESS_WIDTH-1:0]        o_register_address,
  output logic                            o_register_direction,
  output logic [DATA_WIDTH-1:0]           o_register_write_data,
  output logic [DATA_WIDTH-1:0]           o_register_write_mask,
  input  logic [REGISTERS-1:0]            i_register_select,
  input  logic [REGISTERS-1:0]            i_register_ready,
  input  logic [2*REGISTERS-1:0]          i_register_status,
  input  logic [DATA_WIDTH*REGISTERS-1:0] i_register_read_data
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY,
    ST_RESP
  } state_e;

  localparam logic [1:0] STATUS_SLAVE_ERROR  = 2'd2;
  localparam logic [1:0] STATUS_DECODE_ERROR = 2'd3;

  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  state_e                   r_state;
  state_e                   w_next_state;
  logic [ADDRESS_WIDTH-1:0] r_address;
  logic                     r_direction;
  logic [DATA_WIDTH-1:0]    r_write_data;
  logic [DATA_WIDTH-1:0]    r_write_mask;
  logic [DATA_WIDTH-1:0]    r_read_data;
  logic [1:0]               r_status;
  logic [CW-1:0]            r_count;

  logic                     w_setup;
  logic                     w_any_select;
  logic                     w_any_ready;
  logic                     w_multi_ready;
  logic                     w_timeout;
  logic [DATA_WIDTH-1:0]    w_ready_data;
  logic [1:0]               w_ready_status;
  logic                     w_capture;
  logic [DATA_WIDTH-1:0]    w_capture_data;
  logic [1:0]               w_capture_status;
  logic [DATA_WIDTH-1:0]    w_strobe_mask;

  assign w_setup       = i_psel & ~i_penable;
  assign w_any_select  = |i_register_select;
  assign w_any_ready   = |i_register_ready;
  // Clearing the lowest set bit leaves something only if two or more slices are ready.
  assign w_multi_ready = |(i_register_ready & (i_register_ready - REGISTERS'(1)));
  assign w_timeout     = (TIMEOUT_CYCLES != 0) && (r_count == TIMEOUT_LAST);

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    w_ready_data   = '0;
    w_ready_status = '0;
    for (int k = 0; k < REGISTERS; k++) begin
      if (i_register_ready[k]) begin
        w_ready_data   = w_ready_data | i_register_read_data[k*DATA_WIDTH+:DATA_WIDTH];
        w_ready_status = w_ready_status | i_register_status[2*k+:2];
      end
    end
  end

  always_comb begin
    w_strobe_mask = '0;
    for (int i = 0; i < DATA_WIDTH / 8; i++) begin
      w_strobe_mask[8*i+:8] = {8{i_pstrb[i]}};
    end
  end

  always_comb begin
    w_next_state     = r_state;
    w_capture        = 1'b0;
    w_capture_data   = '0;
    w_capture_status = '0;
    case (r_state)
      ST_IDLE: begin
        if (w_setup) begin
          w_next_state = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (!w_any_select) begin
          w_capture        = 1'b1;
          w_capture_status = STATUS_DECODE_ERROR;
          w_next_state     = ST_RESP;
        end else if (w_any_ready) begin
          w_capture        = 1'b1;
          w_capture_data   = w_ready_data;
          w_capture_status = w_multi_ready ? STATUS_SLAVE_ERROR : w_ready_status;
          w_next_state     = ST_RESP;
        end else if (w_timeout) begin
          w_capture        = 1'b1;
          w_capture_status = STATUS_SLAVE_ERROR;
          w_next_state     = ST_RESP;
        end
      end
      ST_RESP: w_next_state = ST_IDLE;
      default: w_next_state = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_address    <= '0;
      r_direction  <= 1'b0;
      r_write_data <= '0;
      r_write_mask <= '0;
      r_read_data  <= '0;
      r_status     <= '0;
      r_count      <= '0;
    end else begin
      if ((r_state == ST_IDLE) && w_setup) begin
        r_address    <= i_paddr;
        r_direction  <= i_pwrite;
        r_write_data <= i_pwdata;
        r_write_mask <= i_pwrite ? w_strobe_mask : '1;
      end
      if (w_capture) begin
        r_read_data <= w_capture_data;
        r_status    <= w_capture_status;
      end
      if ((r_state == ST_BUSY) && !w_capture) begin
        r_count <= r_count + CW'(1);
      end else begin
        r_count <= '0;
      end
    end
  end

  assign o_register_request    = (r_state == ST_BUSY);
  assign o_register_address    = r_address;
  assign o_register_direction  = r_direction;
  assign o_register_write_data = r_write_data;
  assign o_register_write_mask = r_write_mask;

  assign o_pready  = (r_state == ST_RESP);
  assign o_pslverr = o_pready & r_status[1];
  assign o_prdata  = (o_pready && !r_direction) ? r_read_data : '0;

endmodule

// File: tb/tb_rggen_apb_host_adapter.sv
// Directed bench for rggen_apb_host_adapter: two slices driven by the bench, 4-cycle timeout.
module tb_rggen_apb_host_adapter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_psel = 1'b0;
  logic        i_penable = 1'b0;
  logic [15:0] i_paddr = '0;
  logic        i_pwrite = 1'b0;
  logic [31:0] i_pwdata = '0;
  logic [3:0]  i_pstrb = '0;
  logic        o_pready;
  logic [31:0] o_prdata;
  logic        o_pslverr;
  logic        o_register_request;
  logic [15:0] o_register_address;
  logic        o_register_direction;
  logic [31:0] o_register_write_data;
  logic [31:0] o_register_write_mask;
  logic [1:0]  i_register_select = '0;
  logic [1:0]  i_register_ready = '0;
  logic [3:0]  i_register_status = '0;
  logic [63:0] i_register_read_data = '0;

  int pass_cnt = 0;
  int total_cnt = 0;

  rggen_apb_host_adapter #(
    .ADDRESS_WIDTH (16),
    .DATA_WIDTH    (32),
    .REGISTERS     (2),
    .TIMEOUT_CYCLES(4)
  ) dut (
    .clk                  (clk),
    .rst                  (rst),
    .i_psel               (i_psel),
    .i_penable            (i_penable),
    .i_paddr              (i_paddr),
    .i_pwrite             (i_pwrite),
    .i_pwdata             (i_pwdata),
    .i_pstrb              (i_pstrb),
    .o_pready             (o_pready),
    .o_prdata             (o_prdata),
    .o_pslverr            (o_pslverr),
    .o_register_request   (o_register_request),
    .o_register_address   (o_register_address),
    .o_register_direction (o_register_direction),
    .o_register_write_data(o_register_write_data),
    .o_register_write_mask(o_register_write_mask),
    .i_register_select    (i_register_select),
    .i_register_ready     (i_register_ready),
    .i_register_status    (i_register_status),
    .i_register_read_data (i_register_read_data)
  );

  always #5 clk = ~clk;

  // Result of one APB transfer as seen from the bench.
  int          r_lat;
  int          r_req;
  logic [31:0] r_prdata;
  logic        r_pslverr;
  logic        r_stable;
  logic [15:0] r_addr;
  logic        r_dir;
  logic [31:0] r_wdata;
  logic [31:0] r_mask;

  // Drives one transfer starting in the current (idle) cycle; ready_at is the BUSY
  // cycle (1 = first) in which rdy is raised, 0 = never. r_lat = cycle of pready, T0 = setup.
  task automatic run_transfer(input logic [15:0] addr, input logic wr, input logic [31:0] wdata,
                              input logic [3:0] strb, input logic [1:0] sel, input logic [1:0] rdy,
                              input int ready_at, input logic [1:0] st0, input logic [1:0] st1,
                              input logic [31:0] d0, input logic [31:0] d1);
    r_lat = -1; r_req = 0; r_prdata = '0; r_pslverr = 1'b0; r_stable = 1'b1;
    r_addr = '0; r_dir = 1'b0; r_wdata = '0; r_mask = '0;
    i_psel = 1'b1; i_penable = 1'b0; i_paddr = addr; i_pwrite = wr; i_pwdata = wdata; i_pstrb = strb;
    i_register_select = '0; i_register_ready = '0;
    i_register_status = {st1, st0}; i_register_read_data = {d1, d0};
    @(posedge clk); #1;
    i_penable = 1'b1; i_paddr = ~addr; i_pwrite = ~wr; i_pwdata = ~wdata; i_pstrb = ~strb;
    for (int cyc = 1; cyc <= 20; cyc++) begin
      if (o_pready) begin
        r_lat = cyc; r_prdata = o_prdata; r_pslverr = o_pslverr;
        break;
      end
      if (o_register_request) r_req++;
      if (cyc == 1) begin
        r_addr = o_register_address; r_dir = o_register_direction;
        r_wdata = o_register_write_data; r_mask = o_register_write_mask;
      end else if (o_register_address !== r_addr || o_register_direction !== r_dir ||
                   o_register_write_data !== r_wdata || o_register_write_mask !== r_mask) begin
        r_stable = 1'b0;
      end
      i_register_select = sel;
      i_register_ready  = (cyc == ready_at) ? rdy : 2'b00;
      @(posedge clk); #1;
    end
    i_psel = 1'b0; i_penable = 1'b0; i_register_select = '0; i_register_ready = '0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    #1;
    total_cnt++;
    if ({o_pready, o_pslverr, o_register_request, o_register_direction} !== 4'b0000)
      $display("FAIL reset_ctrl: got %b want 0000", {o_pready, o_pslverr, o_register_request, o_register_direction});
    else pass_cnt++;
    total_cnt++;
    if ({o_prdata, o_register_address, o_register_write_data, o_register_write_mask} !== '0)
      $display("FAIL reset_data: prdata=%h addr=%h wdata=%h mask=%h want all 0",
               o_prdata, o_register_address, o_register_write_data, o_register_write_mask);
    else pass_cnt++;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_zero_wait_read;
    run_transfer(16'h0004, 1'b0, 32'h0, 4'h0, 2'b10, 2'b10, 1, 2'd0, 2'd0, 32'h55555555, 32'hDEADBEEF);
    total_cnt++;
    if (r_lat !== 2 || r_req !== 1) $display("FAIL zw_read_timing: lat=%0d req=%0d want 2/1", r_lat, r_req);
    else pass_cnt++;
    total_cnt++;
    if (r_prdata !== 32'hDEADBEEF || r_pslverr !== 1'b0)
      $display("FAIL zw_read_resp: prdata=%h err=%b want deadbeef/0", r_prdata, r_pslverr);
    else pass_cnt++;
    total_cnt++;
    if (r_addr !== 16'h0004 || r_dir !== 1'b0 || r_mask !== 32'hFFFFFFFF)
      $display("FAIL zw_read_req: addr=%h dir=%b mask=%h want 0004/0/ffffffff", r_addr, r_dir, r_mask);
    else pass_cnt++;
  endtask

  task automatic test_write;
    run_transfer(16'h0000, 1'b1, 32'h12345678, 4'b0101, 2'b01, 2'b01, 2, 2'd0, 2'd0, 32'hFFFFFFFF, 32'h0);
    total_cnt++;
    if (r_dir !== 1'b1 || r_mask !== 32'h00FF00FF || r_wdata !== 32'h12345678 || r_addr !== 16'h0000)
      $display("FAIL write_req: dir=%b mask=%h wdata=%h addr=%h want 1/00ff00ff/12345678/0000",
               r_dir, r_mask, r_wdata, r_addr);
    else pass_cnt++;
    total_cnt++;
    if (r_stable !== 1'b1) $display("FAIL write_stable: stable=%b want 1", r_stable);
    else pass_cnt++;
    total_cnt++;
    if (r_lat !== 3 || r_prdata !== 32'h0 || r_pslverr !== 1'b0)
      $display("FAIL write_resp: lat=%0d prdata=%h err=%b want 3/0/0", r_lat, r_prdata, r_pslverr);
    else pass_cnt++;
  endtask

  task automatic test_decode_error;
    run_transfer(16'h0100, 1'b0, 32'h0, 4'h0, 2'b00, 2'b00, 0, 2'd0, 2'd0, 32'hAAAAAAAA, 32'hBBBBBBBB);
    total_cnt++;
    if (r_lat !== 2 || r_req !== 1) $display("FAIL decode_timing: lat=%0d req=%0d want 2/1", r_lat, r_req);
    else pass_cnt++;
    total_cnt++;
    if (r_prdata !== 32'h0 || r_pslverr !== 1'b1)
      $display("FAIL decode_resp: prdata=%h err=%b want 0/1", r_prdata, r_pslverr);
    else pass_cnt++;
  endtask

  task automatic test_timeout;
    run_transfer(16'h0008, 1'b0, 32'h0, 4'h0, 2'b01, 2'b00, 0, 2'd0, 2'd0, 32'h77777777, 32'h0);
    total_cnt++;
    if (r_req !== 4 || r_lat !== 5) $display("FAIL timeout_timing: req=%0d lat=%0d want 4/5", r_req, r_lat);
    else pass_cnt++;
    total_cnt++;
    if (r_pslverr !== 1'b1 || r_prdata !== 32'h0)
      $display("FAIL timeout_resp: err=%b prdata=%h want 1/0", r_pslverr, r_prdata);
    else pass_cnt++;
    run_transfer(16'h0008, 1'b0, 32'h0, 4'h0, 2'b01, 2'b01, 4, 2'd0, 2'd0, 32'h600DCAFE, 32'h0);
    total_cnt++;
    if (r_req !== 4 || r_lat !== 5 || r_pslverr !== 1'b0 || r_prdata !== 32'h600DCAFE)
      $display("FAIL timeout_ready_wins: req=%0d lat=%0d err=%b prdata=%h want 4/5/0/600dcafe",
               r_req, r_lat, r_pslverr, r_prdata);
    else pass_cnt++;
  endtask

  task automatic test_slave_errors;
    run_transfer(16'h0004, 1'b0, 32'h0, 4'h0, 2'b10, 2'b10, 4, 2'd0, 2'd2, 32'h0, 32'h11112222);
    total_cnt++;
    if (r_lat !== 5 || r_pslverr !== 1'b1 || r_prdata !== 32'h11112222)
      $display("FAIL slverr_wait3: lat=%0d err=%b prdata=%h want 5/1/11112222", r_lat, r_pslverr, r_prdata);
    else pass_cnt++;
    run_transfer(16'h0004, 1'b0, 32'h0, 4'h0, 2'b11, 2'b11, 1, 2'd0, 2'd0, 32'h0F0F0000, 32'h000000F0);
    total_cnt++;
    if (r_lat !== 2 || r_pslverr !== 1'b1 || r_prdata !== 32'h0F0F00F0)
      $display("FAIL multi_ready: lat=%0d err=%b prdata=%h want 2/1/0f0f00f0", r_lat, r_pslverr, r_prdata);
    else pass_cnt++;
    run_transfer(16'h0000, 1'b0, 32'h0, 4'h0, 2'b01, 2'b01, 1, 2'd1, 2'd0, 32'h00C0FFEE, 32'h0);
    total_cnt++;
    if (r_pslverr !== 1'b0 || r_prdata !== 32'h00C0FFEE)
      $display("FAIL exokay: err=%b prdata=%h want 0/00c0ffee", r_pslverr, r_prdata);
    else pass_cnt++;
  endtask

  task automatic test_protocol_violation;
    i_psel = 1'b1; i_penable = 1'b1; i_paddr = 16'h0004;
    @(posedge clk); #1;
    total_cnt++;
    if (o_register_request !== 1'b0 || o_pready !== 1'b0)
      $display("FAIL idle_penable_ignored: req=%b pready=%b want 0/0", o_register_request, o_pready);
    else pass_cnt++;
    i_psel = 1'b0; i_penable = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back;
    run_transfer(16'h0004, 1'b0, 32'h0, 4'h0, 2'b10, 2'b10, 1, 2'd0, 2'd0, 32'h0, 32'hA5A5A5A5);
    total_cnt++;
    if (o_pready !== 1'b0 || o_register_request !== 1'b0)
      $display("FAIL b2b_idle_gap: pready=%b req=%b want 0/0", o_pready, o_register_request);
    else pass_cnt++;
    run_transfer(16'h0000, 1'b0, 32'h0, 4'h0, 2'b01, 2'b01, 1, 2'd0, 2'd0, 32'h5A5A5A5A, 32'h0);
    total_cnt++;
    if (r_lat !== 2 || r_prdata !== 32'h5A5A5A5A || r_addr !== 16'h0000)
      $display("FAIL b2b_second: lat=%0d prdata=%h addr=%h want 2/5a5a5a5a/0000", r_lat, r_prdata, r_addr);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_busy;
    i_psel = 1'b1; i_penable = 1'b0; i_paddr = 16'h0004; i_pwrite = 1'b0;
    @(posedge clk); #1;
    i_penable = 1'b1;
    total_cnt++;
    if (o_register_request !== 1'b1) $display("FAIL rst_busy_entry: req=%b want 1", o_register_request);
    else pass_cnt++;
    #2 rst = 1'b1;
    #1;
    total_cnt++;
    if (o_register_request !== 1'b0 || o_pready !== 1'b0 || o_register_address !== 16'h0)
      $display("FAIL rst_async: req=%b pready=%b addr=%h want 0/0/0000",
               o_register_request, o_pready, o_register_address);
    else pass_cnt++;
    i_psel = 1'b0; i_penable = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    run_transfer(16'h0004, 1'b0, 32'h0, 4'h0, 2'b10, 2'b10, 1, 2'd0, 2'd0, 32'h0, 32'hCAFEF00D);
    total_cnt++;
    if (r_lat !== 2 || r_prdata !== 32'hCAFEF00D || r_pslverr !== 1'b0)
      $display("FAIL rst_recovery: lat=%0d prdata=%h err=%b want 2/cafef00d/0", r_lat, r_prdata, r_pslverr);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_zero_wait_read();
    test_write();
    test_decode_error();
    test_timeout();
    test_slave_errors();
    test_protocol_violation();
    test_back_to_back();
    test_reset_mid_busy();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
